mmu_burst: RTL and testbench

//  Parametrised burst memory unit: owns a single-port synchronous RAM and moves
//  a burst of LENGTH words starting at a base address, either writing from a

---
 rtl/mmu_burst.sv | 176 +++++++++++++++++
 tb/tb_mmu_burst.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_burst.sv
// mmu_burst: burst memory unit around a single-port synchronous RAM.
// A burst moves length_i words starting at base_address_i. In write mode the
// words come from a valid/ready stream. In read mode they go out on a
// valid-only stream, delayed by a READ_LATENCY-deep pipeline. done_o pulses
// once at the end of every burst.
//
// Ports
//   clock_i          rising-edge clock
//   reset_n_i        asynchronous active-low reset
//   start_i          begin a burst (sampled only in IDLE)
//   write_enabled_i  burst mode captured with start: 1 = write, 0 = read
//   base_address_i   first word address, captured with start
//   length_i         burst length in words, captured with start
//   wr_data_i        write stream data
//   wr_valid_i       write stream valid
//   wr_ready_o       write word accepted this cycle when wr_valid_i is high
//   rd_data_o        read stream data
//   rd_valid_o       read stream valid (no backpressure)
//   busy_o           burst in progress (WRITE, READ, DRAIN)
//   done_o           one-cycle pulse at burst end
//
// state  | meaning
// IDLE   | waiting for start_i
// WRITE  | accepting stream words into RAM, one per wr_valid_i cycle
// READ   | issuing one RAM read per cycle for length words
// DRAIN  | waiting for the read pipeline to deliver its last word
// FINISH | done_o high for one cycle, then back to IDLE
module mmu_burst #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 6,
  parameter int LEN_W        = 7,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              write_enabled_i,
  input  logic [ADDR_W-1:0] base_address_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_e;

  localparam int DEPTH = 1 << ADDR_W;
  // All pipeline stages except the output stage.
  localparam logic [READ_LATENCY-1:0] NOT_LAST = {READ_LATENCY{1'b1}} >> 1;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic                wr_ready_q;
  logic                busy_q;
  logic                done_q;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   pipe_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_q;

  logic wr_fire;
  logic rd_issue;

  // wr_ready_q is high exactly while in WRITE.
  assign wr_fire  = wr_ready_q && wr_valid_i;
  assign rd_issue = (state_q == S_READ);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= base_address_i;
            rem_q  <= length_i;
            if (length_i == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else if (write_enabled_i) begin
              state_q    <= S_WRITE;
              wr_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= S_READ;
              busy_q  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (wr_valid_i) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_q    <= S_FINISH;
              wr_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        S_READ: begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leave once only the output stage can still hold a word, so done
          // lands in the cycle right after the last rd_valid.
          if ((vld_q & NOT_LAST) == '0) begin
            state_q <= S_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM array is deliberately left out of reset.
  always_ff @(posedge clock_i) begin
    if (wr_fire) begin
      mem[addr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_issue;
      if (rd_issue) begin
        pipe_q[0] <= mem[addr_q];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign wr_ready_o = wr_ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rd_valid_o = vld_q[READ_LATENCY-1];
  assign rd_data_o  = pipe_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mmu_burst.sv
// Bench for mmu_burst: two instances (READ_LATENCY 1 and 3) share all inputs.
// Read expectations (data and arrival cycle) are queued when a read burst is
// issued; per-instance monitors pop and compare on every rd_valid.
module tb_mmu_burst;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        we_i;
  logic [5:0]  base_i;
  logic [6:0]  len_i;
  logic [15:0] wr_data_i;
  logic        wr_valid_i;

  logic        wr_ready1, rd_valid1, busy1, done1;
  logic        wr_ready3, rd_valid3, busy3, done3;
  logic [15:0] rd_data1, rd_data3;

  mmu_burst #(.DATA_W(16), .ADDR_W(6), .LEN_W(7), .READ_LATENCY(1)) u_l1 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start_i), .write_enabled_i(we_i),
    .base_address_i(base_i), .length_i(len_i), .wr_data_i(wr_data_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready1), .rd_data_o(rd_data1),
    .rd_valid_o(rd_valid1), .busy_o(busy1), .done_o(done1)
  );

  mmu_burst #(.DATA_W(16), .ADDR_W(6), .LEN_W(7), .READ_LATENCY(3)) u_l3 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start_i), .write_enabled_i(we_i),
    .base_address_i(base_i), .length_i(len_i), .wr_data_i(wr_data_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready3), .rd_data_o(rd_data3),
    .rd_valid_o(rd_valid3), .busy_o(busy3), .done_o(done3)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [15:0] mdl [64];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_n1  = 0;
  int done_n3  = 0;
  int done_cyc1 = 0;
  int done_cyc3 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: rd_valid with no expected word (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rd_valid1) begin
      if (q1.size() == 0) spurious("rd1_spurious");
      else begin
        e = q1.pop_front();
        chk("rd1_data", 32'(rd_data1), 32'(e.data));
        chk("rd1_cycle", 32'(cyc), e.cyc);
      end
    end
    if (rst_n && done1) begin
      done_n1++;
      done_cyc1 = cyc;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rd_valid3) begin
      if (q3.size() == 0) spurious("rd3_spurious");
      else begin
        e = q3.pop_front();
        chk("rd3_data", 32'(rd_data3), 32'(e.data));
        chk("rd3_cycle", 32'(cyc), e.cyc);
      end
    end
    if (rst_n && done3) begin
      done_n3++;
      done_cyc3 = cyc;
    end
  end

  // Entered and left 1 time unit after a rising edge with the DUTs in IDLE.
  task automatic do_write(input logic [5:0] base, input int len, input logic [15:0] d0,
                          input bit gaps, input bit stray);
    int n, t, b1, b3;
    logic [5:0] a;
    b1 = done_n1;
    b3 = done_n3;
    start_i = 1'b1; we_i = 1'b1; base_i = base; len_i = 7'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0; t = 0; a = base;
    while (n < len && t < 400) begin
      wr_valid_i = !(gaps && t[0]);
      wr_data_i  = d0 + 16'(n);
      if (stray && t == 1) begin
        start_i = 1'b1; we_i = 1'b0; base_i = base + 6'd9; len_i = 7'd2;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      chk("wr_ready1_in_burst", 32'(wr_ready1), 32'd1);
      chk("busy3_in_burst", 32'(busy3), 32'd1);
      @(posedge clk); #1;
      if (wr_valid_i) begin
        mdl[a] = wr_data_i;
        a = a + 6'd1;
        n++;
      end
      t++;
    end
    wr_valid_i = 1'b0;
    start_i    = 1'b0;
    @(negedge clk);
    chk("wr_done1", 32'(done1), 32'd1);
    chk("wr_done3", 32'(done3), 32'd1);
    chk("wr_ready1_after", 32'(wr_ready1), 32'd0);
    chk("wr_busy1_finish", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    chk("wr_done_count1", 32'(done_n1), 32'(b1 + 1));
    chk("wr_done_count3", 32'(done_n3), 32'(b3 + 1));
  endtask

  task automatic do_read(input logic [5:0] base, input int len, input bit stray);
    int c1, b1, b3, e1, e3;
    exp_t e;
    logic [5:0] a;
    b1 = done_n1;
    b3 = done_n3;
    start_i = 1'b1; we_i = 1'b0; base_i = base; len_i = 7'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    c1 = cyc;
    for (int k = 0; k < len; k++) begin
      a = base + 6'(k);
      e.data = mdl[a];
      e.cyc  = 32'(c1 + k + 1);
      q1.push_back(e);
      e.cyc  = 32'(c1 + k + 3);
      q3.push_back(e);
    end
    if (len > 0) begin
      @(negedge clk);
      chk("rd_busy1", 32'(busy1), 32'd1);
      chk("rd_busy3", 32'(busy3), 32'd1);
      if (stray) begin
        start_i = 1'b1; we_i = 1'b1; base_i = base + 6'd5; len_i = 7'd3;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    for (int t = 0; t < len + 20 && !(done_n1 > b1 && done_n3 > b3); t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    e1 = (len == 0) ? c1 : c1 + len + 1;
    e3 = (len == 0) ? c1 : c1 + len + 3;
    chk("rd_done_count1", 32'(done_n1), 32'(b1 + 1));
    chk("rd_done_count3", 32'(done_n3), 32'(b3 + 1));
    chk("rd_done_cycle1", 32'(done_cyc1), 32'(e1));
    chk("rd_done_cycle3", 32'(done_cyc3), 32'(e3));
    chk("rd_q1_empty", 32'(q1.size()), 32'd0);
    chk("rd_q3_empty", 32'(q3.size()), 32'd0);
  endtask

  initial begin
    logic [5:0] rb;
    int rl;
    rst_n = 1'b0; start_i = 1'b0; we_i = 1'b0; base_i = '0; len_i = '0;
    wr_data_i = '0; wr_valid_i = 1'b0;

    // Outputs held at zero during reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready1", 32'(wr_ready1), 32'd0);
    chk("rst_rd_valid1", 32'(rd_valid1), 32'd0);
    chk("rst_rd_data1", 32'(rd_data1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_rd_data3", 32'(rd_data3), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);

    // Mid-cycle release: no spurious activity.
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_no_done", 32'(done_n1 + done_n3), 32'd0);
    chk("post_rst_busy1", 32'(busy1), 32'd0);

    // Reset in the middle of a write burst; the two accepted words stay.
    start_i = 1'b1; we_i = 1'b1; base_i = 6'd10; len_i = 7'd8;
    @(posedge clk); #1;
    start_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = 16'h5A00;
    @(posedge clk); #1;
    mdl[10] = 16'h5A00;
    wr_data_i = 16'h5A01;
    @(posedge clk); #1;
    mdl[11] = 16'h5A01;
    wr_valid_i = 1'b0;
    chk("midrst_busy_before", 32'(busy1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy1", 32'(busy1), 32'd0);
    chk("midrst_wr_ready1", 32'(wr_ready1), 32'd0);
    chk("midrst_busy3", 32'(busy3), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(6'd10, 2, 1'b0);

    // Wrapping write with gaps, then read back at both latencies.
    do_write(6'd62, 4, 16'hA001, 1'b1, 1'b0);
    do_read(6'd62, 4, 1'b0);

    // Zero-length bursts leave memory alone.
    do_write(6'd62, 0, 16'hDEAD, 1'b0, 1'b0);
    do_read(6'd62, 0, 1'b0);
    do_read(6'd62, 4, 1'b0);

    // Stray starts while busy; back-to-back start right after FINISH.
    do_write(6'd20, 6, 16'hB000, 1'b0, 1'b1);
    do_read(6'd20, 6, 1'b1);

    // Fill, then long wrapping bursts and single word at the top address.
    do_write(6'd0, 64, 16'h1000, 1'b0, 1'b0);
    do_write(6'd50, 127, 16'h2000, 1'b1, 1'b0);
    do_read(6'd7, 127, 1'b0);
    do_read(6'd63, 1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rb = 6'($urandom_range(0, 63));
      rl = $urandom_range(0, 127);
      do_write(rb, rl, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      rb = 6'($urandom_range(0, 63));
      rl = $urandom_range(0, 127);
      do_read(rb, rl, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
